// File: rtl/cpu_types_pkg.sv
// CPU-wide type definitions shared by the pipeline stages.
package cpu_types_pkg;

  // Native datapath width of the core.
  localparam int CPU_WORD_W = 32;

  typedef logic [CPU_WORD_W-1:0] word_t;

endpackage

// File: rtl/diaosi_types_pkg.sv
// Types local to the MEM-stage request controller.
package diaosi_types_pkg;

  // Request lifecycle: launch from IDLE, wait for the cache in BUSY,
  // then hold the result in DONE until the pipeline advances.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mem_state_t;

  // Default width of the wait-cycle counter.
  localparam int MEM_CNT_W = 8;

endpackage

// File: rtl/mem_req_ctrl.sv
// MEM-stage data-cache request controller.
// Latches a load/store from ex_mem, holds the cache request until dhit,
// captures load data, and gates the mem_wb latch via wb_en. The DONE
// state keeps a frozen ex_mem instruction from re-issuing.
module mem_req_ctrl
  import diaosi_types_pkg::*;
#(
  parameter int WORD_W = cpu_types_pkg::CPU_WORD_W,
  parameter int CNT_W  = diaosi_types_pkg::MEM_CNT_W
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              mem_valid,
  input  logic              mem_ren,
  input  logic              mem_wen,
  input  logic [WORD_W-1:0] mem_addr,
  input  logic [WORD_W-1:0] mem_store,
  input  logic              flush,
  input  logic              advance,
  input  logic              dhit,
  input  logic [WORD_W-1:0] dmemload,
  output logic              dmemREN,
  output logic              dmemWEN,
  output logic [WORD_W-1:0] dmemaddr,
  output logic [WORD_W-1:0] dmemstore,
  output logic [WORD_W-1:0] load_data,
  output logic              mem_stall,
  output logic              wb_en,
  output logic [CNT_W-1:0]  wait_cnt
);

  mem_state_t        state_q;
  logic              ren_q, wen_q;
  logic [WORD_W-1:0] addr_q, store_q, load_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              req;

  // A flushed instruction never becomes a request.
  assign req = mem_valid & (mem_ren | mem_wen) & ~flush;

  // Saturating increment of the wait counter; sticks at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_q != {CNT_W{1'b1}})
      cnt_d = cnt_q + CNT_W'(1);
  end

  // Request FSM with registered cache strobes and latched operands.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      ren_q   <= 1'b0;
      wen_q   <= 1'b0;
      addr_q  <= '0;
      store_q <= '0;
      load_q  <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req) begin
            addr_q  <= mem_addr;
            store_q <= mem_store;
            // Both flags set is treated as a store, so the strobes stay exclusive.
            wen_q   <= mem_wen;
            ren_q   <= mem_ren & ~mem_wen;
            cnt_q   <= '0;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          // The cache cannot abort, so flush is ignored until dhit.
          cnt_q <= cnt_d;
          if (dhit) begin
            if (ren_q)
              load_q <= dmemload;
            ren_q   <= 1'b0;
            wen_q   <= 1'b0;
            state_q <= DONE;
          end
        end
        DONE: begin
          // Leave only once the pipeline moves the instruction on.
          if (advance)
            state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Stall and writeback-enable decode; forced low while reset is held.
  always_comb begin
    mem_stall = 1'b0;
    wb_en     = 1'b0;
    if (nRST) begin
      case (state_q)
        IDLE: begin
          mem_stall = req;
          wb_en     = advance & ~req;
        end
        BUSY: begin
          mem_stall = 1'b1;
          wb_en     = 1'b0;
        end
        DONE: begin
          mem_stall = 1'b0;
          wb_en     = advance;
        end
        default: begin
          mem_stall = 1'b0;
          wb_en     = 1'b0;
        end
      endcase
    end
  end

  assign dmemREN   = ren_q;
  assign dmemWEN   = wen_q;
  assign dmemaddr  = addr_q;
  assign dmemstore = store_q;
  assign load_data = load_q;
  assign wait_cnt  = cnt_q;

  // The cache must never see a simultaneous read and write strobe.
  strobe_excl_a: assert property (@(posedge CLK) disable iff (!nRST)
    !(ren_q && wen_q));

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Directed bench for mem_req_ctrl (WORD_W=32, CNT_W=8).
module tb_mem_req_ctrl;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        mem_valid, mem_ren, mem_wen;
  logic [31:0] mem_addr, mem_store;
  logic        flush, advance, dhit;
  logic [31:0] dmemload;
  logic        dmemREN, dmemWEN;
  logic [31:0] dmemaddr, dmemstore, load_data;
  logic        mem_stall, wb_en;
  logic [7:0]  wait_cnt;

  int checks   = 0;
  int failures = 0;

  mem_req_ctrl #(.WORD_W(32), .CNT_W(8)) dut (
    .CLK(CLK), .nRST(nRST),
    .mem_valid(mem_valid), .mem_ren(mem_ren), .mem_wen(mem_wen),
    .mem_addr(mem_addr), .mem_store(mem_store),
    .flush(flush), .advance(advance), .dhit(dhit), .dmemload(dmemload),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN),
    .dmemaddr(dmemaddr), .dmemstore(dmemstore), .load_data(load_data),
    .mem_stall(mem_stall), .wb_en(wb_en), .wait_cnt(wait_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge CLK);
    #1;
  endtask

  task automatic smp();
    @(negedge CLK);
  endtask

  initial begin
    nRST = 1'b0;
    mem_valid = 1'b1; mem_ren = 1'b1; mem_wen = 1'b0;
    mem_addr = 32'h0; mem_store = 32'h0;
    flush = 1'b0; advance = 1'b1; dhit = 1'b0; dmemload = 32'h0;
    #3;
    // Reset state, with a pending load on the inputs
    chk1("rst_ren",   dmemREN,   1'b0);
    chk1("rst_wen",   dmemWEN,   1'b0);
    chk1("rst_stall", mem_stall, 1'b0);
    chk1("rst_wb",    wb_en,     1'b0);
    chkw("rst_addr",  dmemaddr,  32'h0);
    chkw("rst_load",  load_data, 32'h0);
    chkw("rst_cnt",   {24'h0, wait_cnt}, 32'h0);
    mem_valid = 1'b0; mem_ren = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;

    // Idle, no request
    nxt(); advance = 1'b1;
    smp(); chk1("idle_stall", mem_stall, 1'b0); chk1("idle_wb", wb_en, 1'b1);

    // Load hit in one cycle
    nxt(); mem_valid = 1'b1; mem_ren = 1'b1; mem_addr = 32'h0000_0040;
    smp(); chk1("ld_launch_stall", mem_stall, 1'b1); chk1("ld_launch_wb", wb_en, 1'b0);
    chk1("ld_launch_ren", dmemREN, 1'b0);
    nxt(); dhit = 1'b1; dmemload = 32'hDEADBEEF;
    smp(); chk1("ld_busy_ren", dmemREN, 1'b1); chk1("ld_busy_wen", dmemWEN, 1'b0);
    chkw("ld_busy_addr", dmemaddr, 32'h40); chk1("ld_busy_stall", mem_stall, 1'b1);
    chk1("ld_busy_wb", wb_en, 1'b0); chkw("ld_busy_cnt", {24'h0, wait_cnt}, 32'd0);
    nxt(); dhit = 1'b0; dmemload = 32'h0;
    smp(); chk1("ld_done_ren", dmemREN, 1'b0); chkw("ld_done_data", load_data, 32'hDEADBEEF);
    chk1("ld_done_wb", wb_en, 1'b1); chk1("ld_done_stall", mem_stall, 1'b0);
    chkw("ld_done_cnt", {24'h0, wait_cnt}, 32'd1);
    nxt(); mem_valid = 1'b0; mem_ren = 1'b0;
    smp(); chk1("ld_idle_ren", dmemREN, 1'b0); chk1("ld_idle_stall", mem_stall, 1'b0);

    // Store with a five-cycle miss
    nxt(); mem_valid = 1'b1; mem_wen = 1'b1; mem_addr = 32'h80; mem_store = 32'h1234;
    smp(); chk1("st_launch_stall", mem_stall, 1'b1);
    for (int i = 0; i < 5; i++) begin
      nxt(); dhit = (i == 4); dmemload = 32'hBAD0BAD0;
      smp(); chk1("st_busy_wen", dmemWEN, 1'b1); chk1("st_busy_ren", dmemREN, 1'b0);
      chk1("st_busy_stall", mem_stall, 1'b1); chk1("st_busy_wb", wb_en, 1'b0);
      chkw("st_busy_data", dmemstore, 32'h1234);
      chkw("st_busy_cnt", {24'h0, wait_cnt}, i);
    end
    nxt(); dhit = 1'b0;
    smp(); chk1("st_done_wen", dmemWEN, 1'b0); chkw("st_done_load", load_data, 32'hDEADBEEF);
    chkw("st_done_cnt", {24'h0, wait_cnt}, 32'd5); chk1("st_done_wb", wb_en, 1'b1);
    chkw("st_done_addr", dmemaddr, 32'h80);

    // Held DONE: instruction stays on the inputs while advance is low
    nxt(); mem_wen = 1'b0; mem_ren = 1'b1; mem_addr = 32'h44;
    smp(); chk1("hd_launch_stall", mem_stall, 1'b1);
    nxt(); dhit = 1'b1; dmemload = 32'hCAFEF00D; advance = 1'b0;
    smp(); chk1("hd_busy_ren", dmemREN, 1'b1);
    nxt(); dhit = 1'b0;
    for (int i = 0; i < 3; i++) begin
      smp(); chk1("hd_hold_ren", dmemREN, 1'b0); chk1("hd_hold_wb", wb_en, 1'b0);
      chk1("hd_hold_stall", mem_stall, 1'b0);
      nxt();
    end
    advance = 1'b1;
    smp(); chk1("hd_rel_wb", wb_en, 1'b1); chkw("hd_rel_load", load_data, 32'hCAFEF00D);

    // Flush in IDLE blocks the launch
    nxt(); flush = 1'b1;
    smp(); chk1("fl_idle_stall", mem_stall, 1'b0); chk1("fl_idle_wb", wb_en, 1'b1);
    advance = 1'b0; #1;
    chk1("fl_idle_wb_adv0", wb_en, 1'b0);
    nxt();
    smp(); chk1("fl_idle_ren", dmemREN, 1'b0); chk1("fl_idle_stall2", mem_stall, 1'b0);
    chkw("fl_idle_cnt_hold", {24'h0, wait_cnt}, 32'd1);

    // Flush during BUSY does not cancel the request
    nxt(); flush = 1'b0; advance = 1'b1; mem_addr = 32'h48;
    smp(); chk1("fb_launch_stall", mem_stall, 1'b1);
    nxt(); flush = 1'b1;
    smp(); chk1("fb_busy_ren", dmemREN, 1'b1); chk1("fb_busy_wb", wb_en, 1'b0);
    chk1("fb_busy_stall", mem_stall, 1'b1);
    nxt(); dhit = 1'b1; dmemload = 32'h55AA55AA;
    smp(); chk1("fb_busy2_ren", dmemREN, 1'b1);
    nxt(); dhit = 1'b0;
    smp(); chk1("fb_done_ren", dmemREN, 1'b0); chkw("fb_done_load", load_data, 32'h55AA55AA);
    chk1("fb_done_wb", wb_en, 1'b1); chkw("fb_done_cnt", {24'h0, wait_cnt}, 32'd2);
    nxt(); flush = 1'b0; mem_valid = 1'b0; mem_ren = 1'b0;

    // Both access flags set: treated as a store
    nxt(); mem_valid = 1'b1; mem_ren = 1'b1; mem_wen = 1'b1; mem_addr = 32'h90; mem_store = 32'h77;
    smp(); chk1("rw_launch_stall", mem_stall, 1'b1);
    nxt(); dhit = 1'b1; dmemload = 32'h11111111;
    smp(); chk1("rw_busy_wen", dmemWEN, 1'b1); chk1("rw_busy_ren", dmemREN, 1'b0);
    chkw("rw_busy_store", dmemstore, 32'h77);
    nxt(); dhit = 1'b0;
    smp(); chk1("rw_done_wen", dmemWEN, 1'b0); chkw("rw_done_load", load_data, 32'h55AA55AA);
    nxt(); mem_valid = 1'b0; mem_ren = 1'b0; mem_wen = 1'b0;

    // Reset asserted in the third BUSY cycle
    nxt(); mem_valid = 1'b1; mem_ren = 1'b1; mem_addr = 32'h4C;
    smp(); chk1("rb_launch_stall", mem_stall, 1'b1);
    nxt(); nxt(); nxt();
    smp(); chk1("rb_busy3_ren", dmemREN, 1'b1); chkw("rb_busy3_cnt", {24'h0, wait_cnt}, 32'd2);
    #2; nRST = 1'b0; #1;
    chk1("rb_ren", dmemREN, 1'b0); chk1("rb_stall", mem_stall, 1'b0); chk1("rb_wb", wb_en, 1'b0);
    chkw("rb_addr", dmemaddr, 32'h0); chkw("rb_load", load_data, 32'h0);
    chkw("rb_cnt", {24'h0, wait_cnt}, 32'd0);
    mem_valid = 1'b0; mem_ren = 1'b0;
    @(negedge CLK); nRST = 1'b1;
    nxt();
    smp(); chk1("rb_rel_ren", dmemREN, 1'b0); chk1("rb_rel_stall", mem_stall, 1'b0);
    chk1("rb_rel_wb", wb_en, 1'b1);
    nxt();
    smp(); chk1("rb_noretry_ren", dmemREN, 1'b0);

    // Wait counter saturation with dhit withheld for 300 cycles
    nxt(); mem_valid = 1'b1; mem_ren = 1'b1; mem_addr = 32'h100;
    smp(); chk1("sat_launch_stall", mem_stall, 1'b1);
    nxt();
    for (int i = 0; i < 300; i++) begin
      smp();
      if (i == 254) chkw("sat_cnt_254", {24'h0, wait_cnt}, 32'd254);
      if (i == 255) chkw("sat_cnt_255", {24'h0, wait_cnt}, 32'd255);
      if (i == 299) begin
        chkw("sat_cnt_299", {24'h0, wait_cnt}, 32'd255);
        chk1("sat_ren", dmemREN, 1'b1); chk1("sat_stall", mem_stall, 1'b1);
      end
      nxt();
    end
    dhit = 1'b1; dmemload = 32'hA5A5A5A5;
    smp(); chkw("sat_cnt_300", {24'h0, wait_cnt}, 32'd255);
    nxt(); dhit = 1'b0;
    smp(); chkw("sat_done_load", load_data, 32'hA5A5A5A5);
    chkw("sat_done_cnt", {24'h0, wait_cnt}, 32'd255); chk1("sat_done_ren", dmemREN, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
